regfile_wr_arbiter: RTL and testbench
=====================================

// Module: regfile_wr_arbiter
// PURPOSE
// Shares the single register-file write port (Rw/busW/RegWr) among NREQ writeback
// requesters (ALU, load, CSR) using round-robin arbitration with valid/ready handshakes.
// Registers the winning write and drives the regfile write port one cycle after acceptance.
// Drops x0 writes and counts them.
// PARAMETERS
// NREQ  3   number of writeback requesters (2..8)
// DW    64  data width (matches `data_width)
// AW    5   register address width (matches `regs_addr)
// PORTS
// clk          in   1        system clock, posedge
// rst_n        in   1        asynchronous active-low reset
// req_valid    in   NREQ     requester i has a write pending
// req_ready    out  NREQ     requester i granted this cycle (one-hot or zero)
// req_addr     in   NREQ*AW  dest reg of requester i, slice [i*AW +: AW]
// req_data     in   NREQ*DW  write data of requester i, slice [i*DW +: DW]
// hold         in   1        suspend all grants (flush/debug halt)
// rf_we        out  1        to regfile RegWr
// rf_waddr     out  AW       to regfile Rw
// rf_wdata     out  DW       to regfile busW
// x0_drop_cnt  out  16       saturating count of accepted writes to x0
// BEHAVIOUR
// - Reset (async, rst_n=0): rf_we=0, rf_waddr=0, rf_wdata=0, x0_drop_cnt=0, rr_ptr=0;
//   req_ready=0 while in reset. Any accepted-but-not-yet-driven write is discarded.
// - Grant (combinational): hold=0 -> scan i = rr_ptr, rr_ptr+1, ... mod NREQ; first i
//   with req_valid[i]=1 gets req_ready[i]=1, all others 0. hold=1 or no valid -> all 0.
// - req_ready depends only on req_valid, rr_ptr, hold; never on req_addr/req_data.
// - Transfer = req_valid[i] & req_ready[i]; at most one per cycle.
// - rr_ptr: on transfer from i -> (i+1) mod NREQ; otherwise unchanged (incl. hold).
// - Write stage, posedge clk:
//   transfer & addr!=0 -> rf_we<=1, rf_waddr<=addr, rf_wdata<=data.
//   transfer & addr==0 -> rf_we<=0, x0_drop_cnt<=min(cnt+1, 16'hFFFF).
//   no transfer        -> rf_we<=0; rf_waddr/rf_wdata hold last value.
// - Latency: accept at edge N -> rf_we high during cycle N+1; regfile writes on the
//   negedge inside that cycle, so the value is readable from the second half of N+1.
//   Throughput: one write per cycle.
// - Requester contract: once req_valid=1, addr/data stable until accepted; the arbiter
//   never retracts req_ready within a cycle.
// - Same-address writes from two requesters: one accepted per cycle in rr order; the
//   later transfer's data persists in the regfile.
// - hold asserted with write in output stage: that write still issues (rf_we=1 for
//   that one cycle); no new grant until hold=0.
// - Fairness: a continuously valid requester is granted within NREQ cycles when hold=0.
// - NREQ=1: rr_ptr constant 0; grant = req_valid & ~hold.
// TESTING
// 1 Reset: rst_n=0 mid-cycle with req_valid=3'b111 -> all outputs 0 immediately,
//   req_ready=0; release -> first grant to req0, rr_ptr=1 after edge.
// 2 Single: req1 valid addr=5 data=64'hDEAD_BEEF -> req_ready=3'b010; next cycle
//   rf_we=1, rf_waddr=5, rf_wdata=64'hDEAD_BEEF; following cycle rf_we=0.
// 3 Round-robin: all three valid for 6 cycles -> grant order 0,1,2,0,1,2; rf_we=1 on
//   cycles 1..6, addresses track the granted requester.
// 4 x0 drop: req2 addr=0 data=64'h1 accepted -> rf_we stays 0, x0_drop_cnt=1; force
//   cnt=16'hFFFF, another x0 write -> stays 16'hFFFF.
// 5 Hold: req0,req2 valid, rr_ptr=1, hold=1 for 3 cycles -> req_ready=0, rf_we=0,
//   rr_ptr stays 1; hold=0 -> req2 granted first, then req0.
// 6 Conflict: req0 and req1 both addr=7 (data A, B), rr_ptr=0 -> A written then B;
//   regfile x7 reads B after second write cycle.

Source files
------------

// File: rtl/regfile_wr_arbiter_if.sv
// Writeback bus shared by the requesters and the regfile write-port arbiter.
// The master side (requesters and regfile) drives the requests and hold.
// The slave side (arbiter) returns the grants and the registered regfile write.
interface regfile_wr_arbiter_if #(
    parameter int NREQ = 3,
    parameter int DW   = 64,
    parameter int AW   = 5
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic               hold;
    logic               rf_we;
    logic [AW-1:0]      rf_waddr;
    logic [DW-1:0]      rf_wdata;
    logic [15:0]        x0_drop_cnt;

    modport master (
        output req_valid, req_addr, req_data, hold,
        input  req_ready, rf_we, rf_waddr, rf_wdata, x0_drop_cnt
    );

    modport slave (
        input  req_valid, req_addr, req_data, hold,
        output req_ready, rf_we, rf_waddr, rf_wdata, x0_drop_cnt
    );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter for the single regfile write port.
// Each cycle it grants one valid writeback requester, starting the search at the
// round-robin pointer. The winning write is registered and presented to the regfile
// in the following cycle. Writes to x0 are never issued; instead they bump a
// saturating drop counter. The hold input freezes all grants, but a write that is
// already in the output register still issues.
module regfile_wr_arbiter #(
    parameter int NREQ = 3,
    parameter int DW   = 64,
    parameter int AW   = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    regfile_wr_arbiter_if.slave   bus
);

    // The pointer keeps at least one bit so the single-requester build still elaborates.
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   rrPtr_q;
    logic [PW-1:0]   rrPtr_d;
    logic [NREQ-1:0] grant;
    logic [PW-1:0]   winner;
    logic            found;
    logic [AW-1:0]   selAddr;
    logic [DW-1:0]   selData;
    logic            transfer;
    logic            x0Hit;

    logic            rfWe_q;
    logic            rfWe_d;
    logic [AW-1:0]   rfWaddr_q;
    logic [AW-1:0]   rfWaddr_d;
    logic [DW-1:0]   rfWdata_q;
    logic [DW-1:0]   rfWdata_d;
    logic [15:0]     x0Cnt_q;
    logic [15:0]     x0Cnt_d;

    // Rotating priority search. Pass one covers indices at or above the pointer and
    // pass two wraps to the indices below it. The grant depends only on valid, the
    // pointer and hold, and is forced low during reset.
    always_comb begin
        grant   = '0;
        winner  = '0;
        found   = 1'b0;
        selAddr = '0;
        selData = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && (i >= int'(rrPtr_q)) && bus.req_valid[i]) begin
                grant[i] = 1'b1;
                winner   = PW'(i);
                selAddr  = bus.req_addr[i*AW +: AW];
                selData  = bus.req_data[i*DW +: DW];
                found    = 1'b1;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!found && (i < int'(rrPtr_q)) && bus.req_valid[i]) begin
                grant[i] = 1'b1;
                winner   = PW'(i);
                selAddr  = bus.req_addr[i*AW +: AW];
                selData  = bus.req_data[i*DW +: DW];
                found    = 1'b1;
            end
        end
        if (bus.hold || !rst_n) begin
            grant = '0;
            found = 1'b0;
        end
    end

    assign bus.req_ready = grant;
    assign transfer      = found;
    assign x0Hit         = transfer && (selAddr == '0);

    // After a transfer, the pointer moves to the requester just past the winner.
    // Otherwise it stays put, and that includes cycles under hold.
    always_comb begin
        rrPtr_d = rrPtr_q;
        if (transfer) begin
            if (int'(winner) == NREQ - 1) begin
                rrPtr_d = '0;
            end else begin
                rrPtr_d = winner + PW'(1);
            end
        end
    end

    // Next value of the write stage. An accepted non-x0 write is loaded into the
    // output register. An accepted x0 write only counts, and the counter saturates.
    // When nothing is accepted, the address and data keep their last values.
    always_comb begin
        rfWe_d    = 1'b0;
        rfWaddr_d = rfWaddr_q;
        rfWdata_d = rfWdata_q;
        x0Cnt_d   = x0Cnt_q;
        if (transfer && !x0Hit) begin
            rfWe_d    = 1'b1;
            rfWaddr_d = selAddr;
            rfWdata_d = selData;
        end
        if (x0Hit && (x0Cnt_q != 16'hFFFF)) begin
            x0Cnt_d = x0Cnt_q + 16'd1;
        end
    end

    // State registers. Reset discards any write that was accepted but not yet driven.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rrPtr_q   <= '0;
            rfWe_q    <= 1'b0;
            rfWaddr_q <= '0;
            rfWdata_q <= '0;
            x0Cnt_q   <= '0;
        end else begin
            rrPtr_q   <= rrPtr_d;
            rfWe_q    <= rfWe_d;
            rfWaddr_q <= rfWaddr_d;
            rfWdata_q <= rfWdata_d;
            x0Cnt_q   <= x0Cnt_d;
        end
    end

    assign bus.rf_we       = rfWe_q;
    assign bus.rf_waddr    = rfWaddr_q;
    assign bus.rf_wdata    = rfWdata_q;
    assign bus.x0_drop_cnt = x0Cnt_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for the regfile write arbiter.
// A table of vectors carries the per-cycle requests together with the hand-computed
// grant and the write-stage result expected after the clock edge. Short hand-written
// sequences cover reset, hold while a write is issuing, and counter saturation.
module tb_regfile_wr_arbiter;

    localparam int NREQ = 3;
    localparam int DW   = 64;
    localparam int AW   = 5;

    localparam logic [63:0] DATA_A = 64'hAAAA_0000_0000_0001;
    localparam logic [63:0] DATA_B = 64'hBBBB_0000_0000_0002;

    typedef struct {
        logic [2:0]  valid;
        logic        hold;
        logic [14:0] addr;
        logic [191:0] data;
        logic [2:0]  expReady;
        logic        expWe;
        logic [4:0]  expWaddr;
        logic [63:0] expWdata;
        logic [15:0] expCnt;
    } vec_t;

    logic clk;
    logic rst_n;
    int   testsRun;
    int   testsFailed;
    vec_t vecs[$];
    logic [63:0] rfModel [32];

    regfile_wr_arbiter_if #(.NREQ(NREQ), .DW(DW), .AW(AW)) bus ();

    regfile_wr_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural regfile that writes on the falling edge inside the rf_we cycle.
    always @(negedge clk) begin
        if (bus.rf_we) begin
            rfModel[bus.rf_waddr] <= bus.rf_wdata;
        end
    end

    function automatic vec_t mk(input logic [2:0] valid, input logic hold,
                                input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                                input logic [63:0] d0, input logic [63:0] d1, input logic [63:0] d2,
                                input logic [2:0] expReady, input logic expWe,
                                input logic [4:0] expWaddr, input logic [63:0] expWdata,
                                input logic [15:0] expCnt);
        vec_t v;
        v.valid    = valid;
        v.hold     = hold;
        v.addr     = {a2, a1, a0};
        v.data     = {d2, d1, d0};
        v.expReady = expReady;
        v.expWe    = expWe;
        v.expWaddr = expWaddr;
        v.expWdata = expWdata;
        v.expCnt   = expCnt;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic drive(input logic [2:0] valid, input logic hold,
                         input logic [14:0] addr, input logic [191:0] data);
        bus.req_valid = valid;
        bus.hold      = hold;
        bus.req_addr  = addr;
        bus.req_data  = data;
    endtask

    // One cycle: drive on the falling edge, check the grant, then check the write stage after the rising edge.
    task automatic applyStimulus(input vec_t v, input string name);
        @(negedge clk);
        drive(v.valid, v.hold, v.addr, v.data);
        #1;
        checkOutput({name, ".ready"}, 64'(bus.req_ready), 64'(v.expReady));
        @(posedge clk);
        #1;
        checkOutput({name, ".we"},    64'(bus.rf_we),       64'(v.expWe));
        checkOutput({name, ".waddr"}, 64'(bus.rf_waddr),    64'(v.expWaddr));
        checkOutput({name, ".wdata"}, bus.rf_wdata,         v.expWdata);
        checkOutput({name, ".cnt"},   64'(bus.x0_drop_cnt), 64'(v.expCnt));
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;

        // Reset sequence.
        vecs.push_back(mk(3'b111, 1'b0, 5'd1, 5'd2, 5'd3, 64'hA0, 64'hA1, 64'hA2, 3'b001, 1'b1, 5'd1, 64'hA0, 16'd0));
        // Single write from req1.
        vecs.push_back(mk(3'b010, 1'b0, 5'd0, 5'd5, 5'd0, 64'h0, 64'hDEAD_BEEF, 64'h0, 3'b010, 1'b1, 5'd5, 64'hDEAD_BEEF, 16'd0));
        vecs.push_back(mk(3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 64'h0, 64'h0, 64'h0, 3'b000, 1'b0, 5'd5, 64'hDEAD_BEEF, 16'd0));
        // Move the pointer back to 0.
        vecs.push_back(mk(3'b100, 1'b0, 5'd0, 5'd0, 5'd12, 64'h0, 64'h0, 64'h102, 3'b100, 1'b1, 5'd12, 64'h102, 16'd0));
        // Round robin with all three valid.
        for (int k = 0; k < 2; k++) begin
            vecs.push_back(mk(3'b111, 1'b0, 5'd10, 5'd11, 5'd12, 64'h100, 64'h101, 64'h102, 3'b001, 1'b1, 5'd10, 64'h100, 16'd0));
            vecs.push_back(mk(3'b111, 1'b0, 5'd10, 5'd11, 5'd12, 64'h100, 64'h101, 64'h102, 3'b010, 1'b1, 5'd11, 64'h101, 16'd0));
            vecs.push_back(mk(3'b111, 1'b0, 5'd10, 5'd11, 5'd12, 64'h100, 64'h101, 64'h102, 3'b100, 1'b1, 5'd12, 64'h102, 16'd0));
        end
        // x0 write is dropped and counted.
        vecs.push_back(mk(3'b100, 1'b0, 5'd0, 5'd0, 5'd0, 64'h0, 64'h0, 64'h1, 3'b100, 1'b0, 5'd12, 64'h102, 16'd1));
        // Pointer to 1, then hold for three cycles.
        vecs.push_back(mk(3'b001, 1'b0, 5'd20, 5'd0, 5'd22, 64'h200, 64'h0, 64'h202, 3'b001, 1'b1, 5'd20, 64'h200, 16'd1));
        for (int k = 0; k < 3; k++) begin
            vecs.push_back(mk(3'b101, 1'b1, 5'd20, 5'd0, 5'd22, 64'h200, 64'h0, 64'h202, 3'b000, 1'b0, 5'd20, 64'h200, 16'd1));
        end
        vecs.push_back(mk(3'b101, 1'b0, 5'd20, 5'd0, 5'd22, 64'h200, 64'h0, 64'h202, 3'b100, 1'b1, 5'd22, 64'h202, 16'd1));
        vecs.push_back(mk(3'b001, 1'b0, 5'd20, 5'd0, 5'd22, 64'h200, 64'h0, 64'h202, 3'b001, 1'b1, 5'd20, 64'h200, 16'd1));
        // Bring the pointer round to 0 for the conflict case.
        vecs.push_back(mk(3'b010, 1'b0, 5'd0, 5'd30, 5'd0, 64'h0, 64'h300, 64'h0, 3'b010, 1'b1, 5'd30, 64'h300, 16'd1));
        vecs.push_back(mk(3'b100, 1'b0, 5'd0, 5'd0, 5'd31, 64'h0, 64'h0, 64'h301, 3'b100, 1'b1, 5'd31, 64'h301, 16'd1));
        // Same-address writes: A first, then B.
        vecs.push_back(mk(3'b011, 1'b0, 5'd7, 5'd7, 5'd0, DATA_A, DATA_B, 64'h0, 3'b001, 1'b1, 5'd7, DATA_A, 16'd1));
        vecs.push_back(mk(3'b010, 1'b0, 5'd7, 5'd7, 5'd0, DATA_A, DATA_B, 64'h0, 3'b010, 1'b1, 5'd7, DATA_B, 16'd1));
        vecs.push_back(mk(3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 64'h0, 64'h0, 64'h0, 3'b000, 1'b0, 5'd7, DATA_B, 16'd1));

        // Power-on reset with every requester asking.
        rst_n = 1'b0;
        drive(3'b111, 1'b0, {5'd3, 5'd2, 5'd1}, {64'hA2, 64'hA1, 64'hA0});
        #3;
        checkOutput("reset.ready", 64'(bus.req_ready), 64'd0);
        checkOutput("reset.we",    64'(bus.rf_we), 64'd0);
        checkOutput("reset.waddr", 64'(bus.rf_waddr), 64'd0);
        checkOutput("reset.wdata", bus.rf_wdata, 64'd0);
        checkOutput("reset.cnt",   64'(bus.x0_drop_cnt), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bus.req_valid = '0;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end

        // A write in the output stage still issues while hold is raised.
        @(negedge clk);
        drive(3'b001, 1'b0, {5'd0, 5'd0, 5'd9}, {64'h0, 64'h0, 64'h900});
        #1;
        checkOutput("holdOut.ready0", 64'(bus.req_ready), 64'b001);
        @(negedge clk);
        drive(3'b101, 1'b1, {5'd22, 5'd0, 5'd9}, {64'h202, 64'h0, 64'h900});
        #1;
        checkOutput("holdOut.ready1", 64'(bus.req_ready), 64'd0);
        checkOutput("holdOut.we",     64'(bus.rf_we), 64'd1);
        checkOutput("holdOut.waddr",  64'(bus.rf_waddr), 64'd9);
        checkOutput("conflict.x7",    rfModel[7], DATA_B);
        @(posedge clk);
        #1;
        checkOutput("holdOut.weAfter", 64'(bus.rf_we), 64'd0);

        // Stream x0 writes until the counter saturates, then one more.
        @(negedge clk);
        drive(3'b111, 1'b0, 15'd0, {64'h3, 64'h2, 64'h1});
        repeat (65534) @(posedge clk);
        #1;
        checkOutput("sat.cnt",  64'(bus.x0_drop_cnt), 64'hFFFF);
        checkOutput("sat.we",   64'(bus.rf_we), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("sat.hold", 64'(bus.x0_drop_cnt), 64'hFFFF);

        // Reset asserted mid-cycle clears everything at once.
        @(negedge clk);
        drive(3'b111, 1'b0, {5'd3, 5'd2, 5'd1}, {64'hA2, 64'hA1, 64'hA0});
        @(posedge clk);
        #1;
        checkOutput("midReset.weBefore", 64'(bus.rf_we), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midReset.ready", 64'(bus.req_ready), 64'd0);
        checkOutput("midReset.we",    64'(bus.rf_we), 64'd0);
        checkOutput("midReset.waddr", 64'(bus.rf_waddr), 64'd0);
        checkOutput("midReset.wdata", bus.rf_wdata, 64'd0);
        checkOutput("midReset.cnt",   64'(bus.x0_drop_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("midReset.grant0", 64'(bus.req_ready), 64'b001);
        @(posedge clk);
        #1;
        checkOutput("midReset.waddr0", 64'(bus.rf_waddr), 64'd1);
        @(negedge clk);
        #1;
        checkOutput("midReset.grant1", 64'(bus.req_ready), 64'b010);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
